// File: rtl/ds_pkg.sv
// Shared types for the channel merger: tagged 36-bit stream word and FSM states.
package ds_pkg;

    typedef logic [35:0] ds_word_t;

    localparam logic [3:0] TAG_STATUS = 4'hF;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        IDLE    = 2'd1,
        CH_DATA = 2'd2,
        TRAILER = 2'd3
    } merger_state_t;

    function automatic ds_word_t make_word(input logic [3:0] tag, input logic [31:0] payload);
        return {tag, payload};
    endfunction

endpackage

// File: rtl/ds_ch_merger.sv
// Drains N_CH show-ahead channel FIFOs once per frame, round-robin, into one tagged
// valid/ready stream closed by a status word carrying the frame counter.
module ds_ch_merger
    import ds_pkg::*;
#(
    parameter int N_CH         = 8,
    parameter int WORDS_PER_CH = 32,
    parameter int TIMEOUT      = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_frame_start,
    input  logic [N_CH*32-1:0]   i_ch_data,
    input  logic [N_CH-1:0]      i_ch_vld,
    output logic [N_CH-1:0]      o_ch_rd,
    output logic [35:0]          o_out_data,
    output logic                 o_out_vld,
    input  logic                 i_out_rdy,
    output logic                 o_busy,
    output logic                 o_overrun,
    output logic                 o_underrun,
    input  logic                 i_clr_flags
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    merger_state_t    state;
    logic [CH_W-1:0]  ch_idx;
    logic [7:0]       word_idx;
    logic [15:0]      tmo;
    logic [31:0]      frame_cnt;

    logic             slot;
    logic             load;
    logic             take;
    logic             pad;
    ds_word_t         load_word;
    logic [31:0]      sel_data;
    logic             sel_vld;

    // A load slot exists whenever the output register is empty or being drained.
    assign slot   = ~o_out_vld | i_out_rdy;
    assign o_busy = (state != IDLE);

    always_comb begin
        sel_data = '0;
        sel_vld  = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_idx == CH_W'(c)) begin
                sel_data = i_ch_data[c*32 +: 32];
                sel_vld  = i_ch_vld[c];
            end
        end
    end

    always_comb begin
        load      = 1'b0;
        take      = 1'b0;
        pad       = 1'b0;
        load_word = '0;
        if (slot) begin
            case (state)
                SYNC: begin
                    load      = 1'b1;
                    load_word = make_word(TAG_STATUS, 32'hFFFF_FFFF);
                end
                CH_DATA: begin
                    if (sel_vld) begin
                        load      = 1'b1;
                        take      = 1'b1;
                        load_word = make_word(4'(ch_idx), sel_data);
                    end else if (tmo == 16'(TIMEOUT)) begin
                        load      = 1'b1;
                        pad       = 1'b1;
                        load_word = make_word(4'(ch_idx), 32'd0);
                    end
                end
                TRAILER: begin
                    load      = 1'b1;
                    load_word = make_word(TAG_STATUS, frame_cnt);
                end
                default: ;
            endcase
        end
    end

    // The read strobe is tied to the load decision, so it can never fire under backpressure.
    always_comb begin
        o_ch_rd = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_ch_rd[c] = take && (ch_idx == CH_W'(c));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            ch_idx     <= '0;
            word_idx   <= '0;
            tmo        <= '0;
            frame_cnt  <= '0;
            o_out_vld  <= 1'b0;
            o_out_data <= '0;
            o_overrun  <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            if (load) begin
                o_out_data <= load_word;
                o_out_vld  <= 1'b1;
            end else if (i_out_rdy) begin
                o_out_vld  <= 1'b0;
            end

            // Sticky flags: a same-cycle set beats the clear.
            o_overrun  <= (i_frame_start && (state != IDLE)) || (o_overrun && !i_clr_flags);
            o_underrun <= pad || (o_underrun && !i_clr_flags);

            case (state)
                SYNC: begin
                    if (load) state <= IDLE;
                end
                IDLE: begin
                    if (i_frame_start) begin
                        state    <= CH_DATA;
                        ch_idx   <= '0;
                        word_idx <= '0;
                        tmo      <= '0;
                    end
                end
                CH_DATA: begin
                    if (load) begin
                        tmo <= '0;
                        if (word_idx == 8'(WORDS_PER_CH - 1)) begin
                            word_idx <= '0;
                            if (ch_idx == CH_W'(N_CH - 1)) begin
                                ch_idx <= '0;
                                state  <= TRAILER;
                            end else begin
                                ch_idx <= ch_idx + 1'b1;
                            end
                        end else begin
                            word_idx <= word_idx + 8'd1;
                        end
                    end else if (slot) begin
                        tmo <= tmo + 16'd1;
                    end
                end
                TRAILER: begin
                    if (load) begin
                        frame_cnt <= frame_cnt + 32'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ds_ch_merger.sv
// Bench for ds_ch_merger: queue-modelled FIFOs, frame-level reference model, directed sequence.
module tb_ds_ch_merger;
    import ds_pkg::*;

    localparam int N_CH        = 8;
    localparam int WPC         = 32;
    localparam int TMO         = 20;
    localparam int FRAME_WORDS = N_CH * WPC;

    logic                clk;
    logic                rst_n;
    logic                i_frame_start;
    logic [N_CH*32-1:0]  i_ch_data;
    logic [N_CH-1:0]     i_ch_vld;
    logic [N_CH-1:0]     o_ch_rd;
    logic [35:0]         o_out_data;
    logic                o_out_vld;
    logic                i_out_rdy;
    logic                o_busy;
    logic                o_overrun;
    logic                o_underrun;
    logic                i_clr_flags;

    ds_ch_merger #(.N_CH(N_CH), .WORDS_PER_CH(WPC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .i_frame_start(i_frame_start),
        .i_ch_data(i_ch_data), .i_ch_vld(i_ch_vld), .o_ch_rd(o_ch_rd),
        .o_out_data(o_out_data), .o_out_vld(o_out_vld), .i_out_rdy(i_out_rdy),
        .o_busy(o_busy), .o_overrun(o_overrun), .o_underrun(o_underrun),
        .i_clr_flags(i_clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] fifo_q [N_CH][$];
    logic [31:0] ref_q  [N_CH][$];

    bit              exp_sync;
    int              pos;
    logic [31:0]     exp_frame;
    int              frames_done;
    int              pads;
    int              frame_rd;
    int              rd_cnt [N_CH];
    logic [N_CH-1:0] pend_rd;
    int              rdy_mode;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int c = 0; c < N_CH; c++) begin
            i_ch_vld[c] = (fifo_q[c].size() != 0);
            i_ch_data[c*32 +: 32] = (fifo_q[c].size() != 0) ? fifo_q[c][0] : 32'd0;
        end
    endtask

    task automatic push(input int c, input int n);
        logic [31:0] d;
        for (int k = 0; k < n; k++) begin
            d = $urandom | 32'h1;
            fifo_q[c].push_back(d);
            ref_q[c].push_back(d);
        end
        refresh();
    endtask

    task automatic top_up(input int c, input int lvl);
        while (fifo_q[c].size() < lvl) push(c, 1);
    endtask

    task automatic top_up_all();
        for (int c = 0; c < N_CH; c++) top_up(c, WPC);
    endtask

    // Reference model: position in frame determines tag; payloads follow per-channel push order.
    task automatic check_word(input logic [35:0] w);
        int t;
        logic [31:0] e;
        if (exp_sync) begin
            chk("sync_word", w, {TAG_STATUS, 32'hFFFF_FFFF});
            exp_sync = 1'b0;
        end else if (pos < FRAME_WORDS) begin
            t = pos / WPC;
            chk("data_tag", w[35:32], t);
            if (w[31:0] == 32'd0) begin
                pads++;
            end else begin
                if (ref_q[t].size() > 0) e = ref_q[t].pop_front();
                else e = 'x;
                chk("data_payload", w[31:0], e);
            end
            pos++;
        end else begin
            chk("status_word", w, {TAG_STATUS, exp_frame});
            exp_frame++;
            pos = 0;
            frames_done++;
        end
    endtask

    always @(negedge clk) begin
        pend_rd = '0;
        if (rst_n) begin
            if (o_ch_rd != '0) begin
                chk("rd_legal", $onehot(o_ch_rd) && (!o_out_vld || i_out_rdy)
                                && ((o_ch_rd & ~i_ch_vld) == '0), 1);
                pend_rd = o_ch_rd;
            end
            if (o_out_vld && i_out_rdy) check_word(o_out_data);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int c = 0; c < N_CH; c++) begin
            if (pend_rd[c]) begin
                if (fifo_q[c].size() > 0) void'(fifo_q[c].pop_front());
                rd_cnt[c]++;
                frame_rd++;
            end
        end
        refresh();
        case (rdy_mode)
            0:       i_out_rdy = 1'b1;
            1:       i_out_rdy = ~i_out_rdy;
            default: i_out_rdy = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        tick();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            tick();
            n++;
        end
        chk("frames_done", frames_done, target);
    endtask

    task automatic wait_pos(input int p, input int budget);
        int n = 0;
        while (pos < p && n < budget) begin
            tick();
            n++;
        end
        chk("reach_pos", pos >= p, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; i_frame_start = 1'b0; i_clr_flags = 1'b0; i_out_rdy = 1'b1;
        i_ch_data = '0; i_ch_vld = '0; rdy_mode = 0;
        exp_sync = 1'b1; pos = 0; exp_frame = 32'd0; frames_done = 0; pads = 0; frame_rd = 0;
        pend_rd = '0;
        for (int c = 0; c < N_CH; c++) rd_cnt[c] = 0;

        // Reset state and SYNC word
        #12;
        chk("reset_outputs", {o_out_vld, o_out_data, o_ch_rd, o_busy, o_overrun, o_underrun},
            {1'b0, 36'd0, 8'd0, 1'b1, 2'b00});
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("sync_seen", exp_sync, 0);
        chk("idle_after_sync", {o_out_vld, o_busy}, 2'b00);

        // Full FIFOs, rdy=1, latency and two frames
        top_up_all();
        frame_rd = 0;
        pulse_start();
        @(negedge clk);
        chk("latency_1clk", o_out_vld, 0);
        @(negedge clk);
        chk("latency_2clk", {o_out_vld, o_out_data[35:32], o_busy}, {1'b1, 4'h0, 1'b1});
        wait_frames(1, 1000);
        chk("rd_count_f0", frame_rd, FRAME_WORDS);
        top_up_all();
        pulse_start();
        wait_frames(2, 1000);
        chk("pads_none", pads, 0);

        // Ready toggling every cycle
        rdy_mode = 1;
        top_up_all();
        frame_rd = 0;
        pulse_start();
        wait_frames(3, 2000);
        chk("rd_count_toggle", frame_rd, FRAME_WORDS);
        rdy_mode = 0;
        repeat (2) tick();

        // Channel 3 runs dry mid-frame for TMO+5 cycles
        for (int c = 0; c < N_CH; c++) top_up(c, (c == 3) ? 10 : WPC);
        pads = 0; frame_rd = 0; rd_cnt[3] = 0;
        pulse_start();
        n = 0;
        while (rd_cnt[3] < 10 && n < 2000) begin
            tick();
            n++;
        end
        chk("ch3_drained", rd_cnt[3], 10);
        repeat (TMO + 5) tick();
        push(3, 21);
        wait_frames(4, 2000);
        chk("one_pad", pads, 1);
        chk("underrun_set", o_underrun, 1);
        chk("rd_count_pad", frame_rd, FRAME_WORDS - 1);
        tick();
        i_clr_flags = 1'b1;
        tick();
        i_clr_flags = 1'b0;
        chk("clr_flags", {o_overrun, o_underrun}, 2'b00);

        // Trigger during CH_DATA, including a clear in the same cycle
        top_up_all();
        frame_rd = 0;
        pulse_start();
        wait_pos(50, 500);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        chk("overrun_set", {o_overrun, o_busy}, 2'b11);
        tick();
        i_frame_start = 1'b1; i_clr_flags = 1'b1;
        tick();
        i_frame_start = 1'b0; i_clr_flags = 1'b0;
        chk("overrun_set_beats_clr", o_overrun, 1);
        wait_frames(5, 1000);
        chk("rd_count_overrun", frame_rd, FRAME_WORDS);
        i_clr_flags = 1'b1;
        tick();
        i_clr_flags = 1'b0;
        chk("overrun_cleared", o_overrun, 0);

        // Reset mid-frame
        top_up_all();
        pulse_start();
        wait_pos(100, 500);
        #1 rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", {o_out_vld, o_out_data, o_ch_rd, o_busy, o_overrun, o_underrun},
            {1'b0, 36'd0, 8'd0, 1'b1, 2'b00});
        exp_sync = 1'b1; pos = 0; exp_frame = 32'd0;
        for (int c = 0; c < N_CH; c++) ref_q[c] = fifo_q[c];
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        while (exp_sync && n < 20) begin
            tick();
            n++;
        end
        chk("resync_word_seen", exp_sync, 0);
        repeat (2) tick();
        top_up_all();
        frame_rd = 0;
        pulse_start();
        wait_frames(6, 1000);
        chk("rd_count_after_reset", frame_rd, FRAME_WORDS);
        chk("frame_cnt_restart", exp_frame, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
